mmio_responder: RTL and testbench

//  Memory-mapped I/O responder at the far end of the EX-stage store/load request (ALU address, lane-shifted

---
 rtl/mmio_responder_pkg.sv | 25 ++
 rtl/mmio_load_align.sv | 37 +++
 rtl/mmio_responder.sv | 136 +++++++++++++
 tb/tb_mmio_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets, load funct3 encodings
// and the TX holding-register state type.
package mmio_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [27:0] OFF_UART_CTRL = 28'h000_0000;
  localparam logic [27:0] OFF_UART_RX   = 28'h000_0004;
  localparam logic [27:0] OFF_UART_TX   = 28'h000_0008;
  localparam logic [27:0] OFF_CYCLE     = 28'h000_0010;
  localparam logic [27:0] OFF_INSTRET   = 28'h000_0014;
  localparam logic [27:0] OFF_CNT_RST   = 28'h000_0018;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/mmio_load_align.sv
// Combinational load alignment: picks byte/half/word from a 32-bit word by address
// offset and sign/zero-extends according to the load funct3.
module mmio_load_align
  import mmio_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = word[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = lanes[lane];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: window decode, UART TX/RX registers, cycle/instret counters and
// a one-cycle registered load return path matching BRAM read latency.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_we,
  input  logic        req_re,
  input  logic [2:0]  req_funct3,
  input  logic        inst_retire,
  output logic        mmio_hit,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [27:0]          offset;
  logic                 load;
  logic                 tx_wr;
  logic                 cnt_clr;
  logic [31:0]          rd_word;
  logic [31:0]          load_data;
  logic [CNT_WIDTH-1:0] cycle_reg;
  logic [CNT_WIDTH-1:0] instret_reg;
  logic [7:0]           tx_data_reg;
  logic                 tx_ovf_reg;
  tx_state_t            state_reg, state_next;
  logic                 tx_latch;
  logic                 tx_drop;
  logic                 unused_wdata;

  assign unused_wdata = ^req_wdata[31:8];

  // Sub-word address bits select lanes; decode works on the word-aligned offset.
  assign offset   = {req_addr[27:2], 2'b00};
  assign mmio_hit = (req_addr[31:28] == MMIO_BASE[31:28]);
  assign load     = mmio_hit && req_re;
  assign tx_wr    = mmio_hit && (offset == OFF_UART_TX) && req_we[0];
  assign cnt_clr  = mmio_hit && (offset == OFF_CNT_RST) && (|req_we);

  assign uart_rx_ready = load && (offset == OFF_UART_RX) && uart_rx_valid && !rst;

  // Reads see register state from before any same-cycle store.
  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_UART_CTRL: rd_word = {29'b0, tx_ovf_reg, uart_rx_valid, uart_tx_valid};
      OFF_UART_RX:   rd_word = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
      OFF_CYCLE:     rd_word = 32'(cycle_reg);
      OFF_INSTRET:   rd_word = 32'(instret_reg);
      default:       rd_word = '0;
    endcase
  end

  mmio_load_align u_align (
    .word   (rd_word),
    .lane   (req_addr[1:0]),
    .funct3 (req_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
    end else begin
      rdata_valid_o <= load;
      rdata_o       <= load ? load_data : 32'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= TX_EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    tx_latch   = 1'b0;
    tx_drop    = 1'b0;
    case (state_reg)
      TX_EMPTY: begin
        if (tx_wr) begin
          tx_latch   = 1'b1;
          state_next = TX_FULL;
        end
      end
      TX_FULL: begin
        // A write racing the handshake is still dropped: the byte was not yet free.
        tx_drop = tx_wr;
        if (uart_tx_ready) state_next = TX_EMPTY;
      end
      default: state_next = TX_EMPTY;
    endcase
  end

  assign uart_tx_valid = (state_reg == TX_FULL);
  assign uart_tx_data  = tx_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_reg <= '0;
      tx_ovf_reg  <= 1'b0;
    end else begin
      if (tx_latch) tx_data_reg <= req_wdata[7:0];
      if (tx_drop)  tx_ovf_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else if (cnt_clr) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + CNT_ONE;
      if (inst_retire) instret_reg <= instret_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: reset, decode, loads with alignment, UART RX/TX,
// counters (including wrap on a narrow-counter instance) and asynchronous reset.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_we;
  logic        req_re;
  logic [2:0]  req_funct3;
  logic        inst_retire;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;

  logic        mmio_hit;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_rx_ready;

  logic        w_mmio_hit;
  logic [31:0] w_rdata_o;
  logic        w_rdata_valid_o;
  logic [7:0]  w_uart_tx_data;
  logic        w_uart_tx_valid;
  logic        w_uart_rx_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .req_re(req_re), .req_funct3(req_funct3), .inst_retire(inst_retire),
    .mmio_hit(mmio_hit), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  mmio_responder #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .req_re(req_re), .req_funct3(req_funct3), .inst_retire(inst_retire),
    .mmio_hit(w_mmio_hit), .rdata_o(w_rdata_o), .rdata_valid_o(w_rdata_valid_o),
    .uart_tx_data(w_uart_tx_data), .uart_tx_valid(w_uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(w_uart_rx_ready)
  );

  task automatic drive_idle();
    req_addr = 32'h0; req_wdata = 32'h0; req_we = 4'h0; req_re = 1'b0;
    req_funct3 = 3'b010; inst_retire = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3);
    req_addr = addr; req_funct3 = f3; req_re = 1'b1; req_we = 4'h0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    req_addr = addr; req_wdata = wdata; req_we = we; req_re = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle(); uart_tx_ready = 1'b0; uart_rx_data = 8'hA5; uart_rx_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    drive_load(32'h8000_0004, 3'b010);
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", uart_rx_ready); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid_o); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", uart_tx_data); end
    req_addr = 32'h8000_0010; #1;
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL hit_in_window: got %b want 1", mmio_hit); end
    req_addr = 32'h0000_1000; #1;
    checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL hit_outside: got %b want 0", mmio_hit); end
    drive_idle(); uart_rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_cycle_read();
    repeat (11) @(negedge clk);
    drive_load(32'h8000_0010, 3'b010);
    @(negedge clk);
    drive_idle();
    $display("lw 0x80000010 -> %h valid %b", rdata_o, rdata_valid_o);
    checks++; if (rdata_o !== 32'd11) begin errors++; $display("FAIL cycle_read: got %0d want 11", rdata_o); end
    checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL cycle_valid: got %b want 1", rdata_valid_o); end
    @(negedge clk);
    checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b want 0", rdata_valid_o); end
  endtask

  task automatic test_miss();
    drive_load(32'h4000_0010, 3'b010);
    @(negedge clk);
    drive_idle();
    $display("lw 0x40000010 -> valid %b", rdata_valid_o);
    checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b want 0", rdata_valid_o); end
  endtask

  task automatic test_rx();
    uart_rx_valid = 1'b1; uart_rx_data = 8'hF0;
    drive_load(32'h8000_0004, 3'b000);
    #1;
    checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_pop: got %b want 1", uart_rx_ready); end
    @(negedge clk);
    drive_idle(); #1;
    $display("lb 0x80000004 -> %h", rdata_o);
    checks++; if (rdata_o !== 32'hFFFF_FFF0) begin errors++; $display("FAIL rx_lb: got %h want fffffff0", rdata_o); end
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_pop_pulse: got %b want 0", uart_rx_ready); end
    drive_load(32'h8000_0004, 3'b100);
    @(negedge clk);
    $display("lbu 0x80000004 -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h0000_00F0) begin errors++; $display("FAIL rx_lbu: got %h want 000000f0", rdata_o); end
    drive_load(32'h8000_0005, 3'b000);
    @(negedge clk);
    $display("lb 0x80000005 -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rx_lb_lane1: got %h want 0", rdata_o); end
    uart_rx_valid = 1'b0;
    drive_load(32'h8000_0004, 3'b010);
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_empty_pop: got %b want 0", uart_rx_ready); end
    @(negedge clk);
    drive_idle();
    $display("lw 0x80000004 (rx empty) -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rx_empty_data: got %h want 0", rdata_o); end
  endtask

  task automatic test_tx();
    uart_tx_ready = 1'b0;
    drive_store(32'h8000_0008, 32'h0000_0041, 4'b0001);
    @(negedge clk);
    $display("sb 0x41 -> tx_valid %b tx_data %h", uart_tx_valid, uart_tx_data);
    checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_set: got %b want 1", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_data: got %h want 41", uart_tx_data); end
    drive_store(32'h8000_0008, 32'h0000_0042, 4'b0001);
    @(negedge clk);
    $display("sb 0x42 (full) -> tx_data %h", uart_tx_data);
    checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_drop: got %h want 41", uart_tx_data); end
    drive_load(32'h8000_0000, 3'b010);
    @(negedge clk);
    $display("lw ctrl -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h5) begin errors++; $display("FAIL ctrl_full_ovf: got %h want 5", rdata_o); end
    drive_idle(); uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_handshake_clear: got %b want 0", uart_tx_valid); end
    drive_load(32'h8000_0000, 3'b010);
    @(negedge clk);
    $display("lw ctrl after drain -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h4) begin errors++; $display("FAIL ctrl_ovf_sticky: got %h want 4", rdata_o); end
    drive_store(32'h8000_0008, 32'h0000_7700, 4'b0010);
    @(negedge clk);
    drive_idle();
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_we0_only: got %b want 0", uart_tx_valid); end
  endtask

  task automatic test_counters();
    drive_store(32'h8000_0018, 32'h0, 4'hF); inst_retire = 1'b1;
    @(negedge clk);
    inst_retire = 1'b0;
    drive_load(32'h8000_0010, 3'b010);
    @(negedge clk);
    $display("lw cycle after clear -> %h / %h", rdata_o, w_rdata_o);
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL cycle_clear: got %h want 0", rdata_o); end
    checks++; if (w_rdata_o !== 32'h0) begin errors++; $display("FAIL cycle_clear_w: got %h want 0", w_rdata_o); end
    drive_load(32'h8000_0014, 3'b010);
    @(negedge clk);
    $display("lw instret after clear -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL instret_clear: got %h want 0", rdata_o); end
    drive_idle(); inst_retire = 1'b1;
    repeat (3) @(negedge clk);
    inst_retire = 1'b0;
    drive_load(32'h8000_0014, 3'b010);
    @(negedge clk);
    drive_idle();
    $display("lw instret after 3 retires -> %h", rdata_o);
    checks++; if (rdata_o !== 32'd3) begin errors++; $display("FAIL instret_count: got %0d want 3", rdata_o); end
    repeat (9) @(negedge clk);
    drive_load(32'h8000_0010, 3'b010);
    @(negedge clk);
    $display("lw cycle back-to-back #1 -> %h / %h", rdata_o, w_rdata_o);
    checks++; if (w_rdata_o !== 32'hF) begin errors++; $display("FAIL wrap_max_w: got %h want f", w_rdata_o); end
    checks++; if (rdata_o !== 32'd15) begin errors++; $display("FAIL cycle_15: got %0d want 15", rdata_o); end
    @(negedge clk);
    drive_idle();
    $display("lw cycle back-to-back #2 -> %h / %h", rdata_o, w_rdata_o);
    checks++; if (w_rdata_o !== 32'h0) begin errors++; $display("FAIL wrap_zero_w: got %h want 0", w_rdata_o); end
    checks++; if (rdata_o !== 32'd16) begin errors++; $display("FAIL cycle_16: got %0d want 16", rdata_o); end
    checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rdata_valid_o); end
  endtask

  task automatic test_async_reset();
    uart_tx_ready = 1'b0;
    drive_store(32'h8000_0008, 32'h0000_0055, 4'b0001);
    @(negedge clk);
    drive_store(32'h8000_0008, 32'h0000_0066, 4'b0001);
    @(negedge clk);
    drive_load(32'h8000_0010, 3'b010);
    @(posedge clk);
    #2;
    checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL pending_valid: got %b want 1", rdata_valid_o); end
    rst = 1'b1;
    #1;
    $display("async rst -> valid %b tx_valid %b", rdata_valid_o, uart_tx_valid);
    checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", rdata_valid_o); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL arst_tx_valid: got %b want 0", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h0) begin errors++; $display("FAIL arst_tx_data: got %h want 0", uart_tx_data); end
    @(negedge clk);
    drive_idle(); rst = 1'b0;
    drive_load(32'h8000_0000, 3'b010);
    @(negedge clk);
    drive_idle();
    $display("lw ctrl after rst -> %h", rdata_o);
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL ctrl_after_rst: got %h want 0", rdata_o); end
  endtask

  initial begin
    test_reset();
    test_cycle_read();
    test_miss();
    test_rx();
    test_tx();
    test_counters();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
